mem_bus_arbiter: RTL and testbench

Two-port arbiter and sequencer for the shared memory bus behind the pair of snooping MSI caches. Each cache presents a read or write-back request on its `rwToMem`/`addrToMem`/`dataToMem` outputs. This block grants one cache at a time and drives a single req/ack memory port. It returns a one-cycle completion pulse (`readEn…`/`writeDone…`) to the granted cache. Write-backs take priority over reads so that a snooped write-back reaches memory before the other cache's refill.

---
 rtl/mem_bus_if.sv | 29 ++
 rtl/mem_bus_arbiter.sv | 163 ++++++++++++++++
 tb/tb_mem_bus_arbiter.sv | 305 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_bus_if.sv
// mem_bus_if: single req/ack memory port shared by both caches.
//   memReq   - request held high until acknowledged or abandoned
//   memWe    - 1 = write, 0 = read
//   memAddr  - request address
//   memWdata - write data
//   memAck   - one-cycle acknowledge; memRdata is valid in that cycle
//   memRdata - read data from memory
// The master modport is the arbiter side; the slave modport is the memory.
interface mem_bus_if #(
    parameter int ADDRWIDTH = 16,
    parameter int WORDWIDTH = 16
);
    logic                 memReq;
    logic                 memWe;
    logic [ADDRWIDTH-1:0] memAddr;
    logic [WORDWIDTH-1:0] memWdata;
    logic                 memAck;
    logic [WORDWIDTH-1:0] memRdata;

    modport master (
        output memReq, memWe, memAddr, memWdata,
        input  memAck, memRdata
    );

    modport slave (
        input  memReq, memWe, memAddr, memWdata,
        output memAck, memRdata
    );
endinterface

// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter: grants one of two snooping caches at a time onto a single
// req/ack memory port. Write-backs beat reads; ties go to the round-robin
// favourite. Each granted transaction ends with a one-cycle completion pulse
// to the owner, or, if memory never answers, a sticky timeout flag.
//   clk, reset                  - clock, asynchronous active-high reset
//   rwFromCacheN                - RD=0, WT=1, IDEL=2 (3 = no request)
//   addrFromCacheN/dataFromCacheN - request address / write data
//   readEnToCacheN              - read-complete pulse
//   writeDoneToCacheN           - write-complete pulse
//   dataToCaches                - data of the most recent completed read
//   addrToCaches                - address of the current/last grant
//   grant                       - one-hot owner, 0 when idle
//   timeoutErr                  - sticky memory timeout flag
//   mem                         - memory port (master side)
module mem_bus_arbiter #(
    parameter int ADDRWIDTH = 16,
    parameter int WORDWIDTH = 16,
    parameter int TIMEOUT   = 255
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [1:0]           rwFromCache0,
    input  logic [1:0]           rwFromCache1,
    input  logic [ADDRWIDTH-1:0] addrFromCache0,
    input  logic [ADDRWIDTH-1:0] addrFromCache1,
    input  logic [WORDWIDTH-1:0] dataFromCache0,
    input  logic [WORDWIDTH-1:0] dataFromCache1,
    output logic                 readEnToCache0,
    output logic                 readEnToCache1,
    output logic                 writeDoneToCache0,
    output logic                 writeDoneToCache1,
    output logic [WORDWIDTH-1:0] dataToCaches,
    output logic [ADDRWIDTH-1:0] addrToCaches,
    output logic [1:0]           grant,
    output logic                 timeoutErr,
    mem_bus_if.master            mem
);

    localparam logic [1:0] RW_RD = 2'd0;
    localparam logic [1:0] RW_WT = 2'd1;

    localparam int              CNT_W    = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_BUSY,
        S_DONE
    } state_t;

    state_t           state, next_state;
    logic             rr_ptr;      // 0 favours cache0, 1 favours cache1
    logic [CNT_W-1:0] tmo_cnt;     // BUSY cycles spent without memAck

    logic wt0, wt1, rd0, rd1;
    logic pick1;                   // arbitration result: 1 = cache1 wins
    logic start, acked, timed_out;

    assign wt0 = (rwFromCache0 == RW_WT);
    assign wt1 = (rwFromCache1 == RW_WT);
    assign rd0 = (rwFromCache0 == RW_RD);
    assign rd1 = (rwFromCache1 == RW_RD);

    // Write class first, then read class; a tie within a class (including
    // the no-request case, which is never used) goes to the pointer.
    always_comb begin
        if (wt0 != wt1)      pick1 = wt1;
        else if (wt0)        pick1 = rr_ptr;
        else if (rd0 != rd1) pick1 = rd1;
        else                 pick1 = rr_ptr;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= S_IDLE;
        else       state <= next_state;
    end

    // NOTE: every combinational output gets a default before the case so no
    // path leaves it unassigned and a latch can never be inferred.
    always_comb begin
        next_state = state;
        start      = 1'b0;
        acked      = 1'b0;
        timed_out  = 1'b0;
        case (state)
            S_IDLE: begin
                if (wt0 || wt1 || rd0 || rd1) begin
                    next_state = S_BUSY;
                    start      = 1'b1;
                end
            end
            S_BUSY: begin
                if (mem.memAck) begin
                    next_state = S_DONE;
                    acked      = 1'b1;
                end else if (tmo_cnt == CNT_LAST) begin
                    next_state = S_IDLE;
                    timed_out  = 1'b1;
                end
            end
            S_DONE:  next_state = S_IDLE;
            default: next_state = S_IDLE;
        endcase
    end

    // NOTE: registered state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rr_ptr            <= 1'b0;
            tmo_cnt           <= '0;
            grant             <= '0;
            mem.memReq        <= 1'b0;
            mem.memWe         <= 1'b0;
            mem.memAddr       <= '0;
            mem.memWdata      <= '0;
            addrToCaches      <= '0;
            dataToCaches      <= '0;
            readEnToCache0    <= 1'b0;
            readEnToCache1    <= 1'b0;
            writeDoneToCache0 <= 1'b0;
            writeDoneToCache1 <= 1'b0;
            timeoutErr        <= 1'b0;
        end else begin
            // Completion pulses live for exactly one cycle.
            readEnToCache0    <= 1'b0;
            readEnToCache1    <= 1'b0;
            writeDoneToCache0 <= 1'b0;
            writeDoneToCache1 <= 1'b0;

            if (start) begin
                grant        <= {pick1, ~pick1};
                rr_ptr       <= ~pick1;
                tmo_cnt      <= '0;
                mem.memReq   <= 1'b1;
                mem.memWe    <= pick1 ? wt1 : wt0;
                mem.memAddr  <= pick1 ? addrFromCache1 : addrFromCache0;
                mem.memWdata <= pick1 ? dataFromCache1 : dataFromCache0;
                addrToCaches <= pick1 ? addrFromCache1 : addrFromCache0;
            end

            if (acked) begin
                mem.memReq <= 1'b0;
                // memWe still holds the latched class of the granted request.
                if (!mem.memWe) dataToCaches <= mem.memRdata;
                readEnToCache0    <= grant[0] & ~mem.memWe;
                readEnToCache1    <= grant[1] & ~mem.memWe;
                writeDoneToCache0 <= grant[0] &  mem.memWe;
                writeDoneToCache1 <= grant[1] &  mem.memWe;
            end else if (timed_out) begin
                mem.memReq <= 1'b0;
                grant      <= '0;
                timeoutErr <= 1'b1;
            end else if (state == S_BUSY && tmo_cnt != CNT_MAX) begin
                tmo_cnt <= tmo_cnt + 1'b1;
            end

            if (state == S_DONE) grant <= '0;
        end
    end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// tb_mem_bus_arbiter: directed scenarios with literal expectations followed by
// randomized traffic, all checked every cycle against a transaction-level
// model of the arbiter kept in this file.
module tb_mem_bus_arbiter;

    localparam int AW         = 16;
    localparam int WW         = 16;
    localparam int TB_TIMEOUT = 4;
    localparam logic [1:0] RD = 2'd0, WT = 2'd1, IDEL = 2'd2, ILL = 2'd3;

    logic          clk = 1'b0;
    logic          reset;
    logic [1:0]    rw0, rw1;
    logic [AW-1:0] addr0, addr1;
    logic [WW-1:0] data0, data1;
    logic          rd_en0, rd_en1, wr_done0, wr_done1;
    logic [WW-1:0] data_to_caches;
    logic [AW-1:0] addr_to_caches;
    logic [1:0]    grant;
    logic          timeout_err;

    mem_bus_if #(.ADDRWIDTH(AW), .WORDWIDTH(WW)) bus ();

    mem_bus_arbiter #(.ADDRWIDTH(AW), .WORDWIDTH(WW), .TIMEOUT(TB_TIMEOUT)) dut (
        .clk               (clk),
        .reset             (reset),
        .rwFromCache0      (rw0),
        .rwFromCache1      (rw1),
        .addrFromCache0    (addr0),
        .addrFromCache1    (addr1),
        .dataFromCache0    (data0),
        .dataFromCache1    (data1),
        .readEnToCache0    (rd_en0),
        .readEnToCache1    (rd_en1),
        .writeDoneToCache0 (wr_done0),
        .writeDoneToCache1 (wr_done1),
        .dataToCaches      (data_to_caches),
        .addrToCaches      (addr_to_caches),
        .grant             (grant),
        .timeoutErr        (timeout_err),
        .mem               (bus)
    );

    always #5 clk = ~clk;

    int vectors    = 0;
    int miscompares = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- transaction-level reference model ----------------
    // A transaction is "in flight" from its grant until it is either retired
    // one cycle after memAck or abandoned after TB_TIMEOUT unanswered cycles.
    int            m_owner;      // owning port of the in-flight transaction
    bit            m_in_flight;
    bit            m_retiring;   // ack seen; retires on the next edge
    bit            m_write;
    int            m_waited;
    int            m_favored;    // port that wins a same-class tie
    logic [1:0]    e_grant, e_rd, e_wd;
    logic          e_req, e_we, e_terr;
    logic [AW-1:0] e_addr, e_addrc;
    logic [WW-1:0] e_wdata, e_data;

    function automatic int class_rank(input logic [1:0] rw);
        return (rw == WT) ? 2 : (rw == RD) ? 1 : 0;
    endfunction

    function automatic int pick_winner(input logic [1:0] a, input logic [1:0] b, input int fav);
        int ra = class_rank(a);
        int rb = class_rank(b);
        if (ra == 0 && rb == 0) return -1;
        if (ra > rb) return 0;
        if (rb > ra) return 1;
        return fav;
    endfunction

    task automatic model_reset();
        m_owner = 0; m_in_flight = 0; m_retiring = 0; m_write = 0;
        m_waited = 0; m_favored = 0;
        e_grant = '0; e_rd = '0; e_wd = '0; e_req = 0; e_we = 0; e_terr = 0;
        e_addr = '0; e_addrc = '0; e_wdata = '0; e_data = '0;
    endtask

    // Advance the model by one clock edge using the inputs present before it.
    task automatic model_step();
        int w;
        e_rd = '0;
        e_wd = '0;
        if (m_in_flight && m_retiring) begin
            m_in_flight = 0;
            e_grant     = '0;
        end else if (m_in_flight) begin
            if (bus.memAck) begin
                m_retiring = 1;
                e_req      = 0;
                if (m_write) e_wd[m_owner] = 1'b1;
                else begin
                    e_rd[m_owner] = 1'b1;
                    e_data        = bus.memRdata;
                end
            end else begin
                m_waited++;
                if (m_waited == TB_TIMEOUT) begin
                    m_in_flight = 0;
                    e_req       = 0;
                    e_grant     = '0;
                    e_terr      = 1;
                end
            end
        end else begin
            w = pick_winner(rw0, rw1, m_favored);
            if (w >= 0) begin
                m_in_flight = 1;
                m_retiring  = 0;
                m_waited    = 0;
                m_owner     = w;
                m_favored   = 1 - w;
                m_write     = ((w == 0) ? rw0 : rw1) == WT;
                e_grant     = 2'(1 << w);
                e_req       = 1;
                e_we        = m_write;
                e_addr      = (w == 0) ? addr0 : addr1;
                e_wdata     = (w == 0) ? data0 : data1;
                e_addrc     = e_addr;
            end
        end
    endtask

    task automatic compare_all();
        check("grant", grant, e_grant);
        check("memReq", bus.memReq, e_req);
        if (e_req) begin
            check("memWe", bus.memWe, e_we);
            check("memAddr", bus.memAddr, e_addr);
            if (e_we) check("memWdata", bus.memWdata, e_wdata);
        end
        check("readEn0", rd_en0, e_rd[0]);
        check("readEn1", rd_en1, e_rd[1]);
        check("writeDone0", wr_done0, e_wd[0]);
        check("writeDone1", wr_done1, e_wd[1]);
        check("dataToCaches", data_to_caches, e_data);
        check("addrToCaches", addr_to_caches, e_addrc);
        check("timeoutErr", timeout_err, e_terr);
    endtask

    // One clock: model follows the edge, DUT is compared half a cycle later.
    task automatic step();
        @(posedge clk);
        model_step();
        @(negedge clk);
        compare_all();
    endtask

    task automatic set_req(input logic [1:0] r0, input logic [AW-1:0] a0, input logic [WW-1:0] d0,
                           input logic [1:0] r1, input logic [AW-1:0] a1, input logic [WW-1:0] d1);
        rw0 = r0; addr0 = a0; data0 = d0;
        rw1 = r1; addr1 = a1; data1 = d1;
    endtask

    logic [1:0] rr_seen [4];
    logic [1:0] rr_want [4];

    initial begin
        reset = 1'b1;
        set_req(IDEL, '0, '0, IDEL, '0, '0);
        bus.memAck   = 1'b0;
        bus.memRdata = '0;
        model_reset();
        @(negedge clk);
        @(negedge clk);
        compare_all();
        check("reset memReq", bus.memReq, 0);
        check("reset memAddr", bus.memAddr, 0);
        check("reset memWdata", bus.memWdata, 0);
        check("reset memWe", bus.memWe, 0);
        reset = 1'b0;

        // Single read from cache0, answered after a short wait.
        set_req(RD, 16'h1234, 16'h0, IDEL, '0, '0);
        step();
        check("read memReq", bus.memReq, 1);
        check("read memWe", bus.memWe, 0);
        check("read memAddr", bus.memAddr, 16'h1234);
        check("read grant", grant, 2'b01);
        rw0 = IDEL;
        step();
        step();
        bus.memAck = 1'b1; bus.memRdata = 16'hBEEF;
        step();
        check("read pulse0", rd_en0, 1);
        check("read pulse1", rd_en1, 0);
        check("read data", data_to_caches, 16'hBEEF);
        bus.memAck = 1'b0; bus.memRdata = 16'h0;
        step();
        check("read pulse0 gone", rd_en0, 0);
        check("read grant clear", grant, 2'b00);

        // Write-back from cache1 beats a simultaneous read from cache0.
        set_req(RD, 16'h0010, 16'h0, WT, 16'h0020, 16'h5A5A);
        step();
        check("prio grant", grant, 2'b10);
        check("prio memWe", bus.memWe, 1);
        check("prio memWdata", bus.memWdata, 16'h5A5A);
        check("prio memAddr", bus.memAddr, 16'h0020);
        rw1 = IDEL; bus.memAck = 1'b1;
        step();
        check("prio writeDone1", wr_done1, 1);
        bus.memAck = 1'b0;
        step();
        step();
        check("prio second grant", grant, 2'b01);
        check("prio second addr", bus.memAddr, 16'h0010);
        rw0 = IDEL; bus.memAck = 1'b1; bus.memRdata = 16'h0AAA;
        step();
        bus.memAck = 1'b0;
        step();

        // Encoding 3 on cache0 is no request; only cache1 is served.
        set_req(ILL, 16'h7777, 16'h1111, RD, 16'h0044, 16'h0);
        step();
        check("illegal grant", grant, 2'b10);
        check("illegal terr", timeout_err, 0);
        bus.memAck = 1'b1; bus.memRdata = 16'h4444;
        set_req(IDEL, '0, '0, IDEL, '0, '0);
        step();
        bus.memAck = 1'b0;
        step();

        // Memory never answers: abandoned after TB_TIMEOUT busy cycles.
        set_req(RD, 16'h0300, 16'h0, IDEL, '0, '0);
        step();
        check("tmo grant", grant, 2'b01);
        rw0 = IDEL;
        for (int i = 1; i < TB_TIMEOUT; i++) begin
            step();
            check("tmo memReq held", bus.memReq, 1);
        end
        step();
        check("tmo memReq drop", bus.memReq, 0);
        check("tmo flag", timeout_err, 1);
        check("tmo grant clear", grant, 2'b00);
        check("tmo no pulse", rd_en0, 0);
        set_req(IDEL, '0, '0, RD, 16'h0500, 16'h0);
        step();
        check("tmo next grant", grant, 2'b10);
        rw1 = IDEL; bus.memAck = 1'b1; bus.memRdata = 16'h1357;
        step();
        check("tmo next pulse", rd_en1, 1);
        check("tmo next data", data_to_caches, 16'h1357);
        bus.memAck = 1'b0;
        step();

        // Reset between edges in the middle of a transaction.
        set_req(RD, 16'h0600, 16'h0, IDEL, '0, '0);
        step();
        #2 reset = 1'b1;
        model_reset();
        #1;
        compare_all();
        check("midreset memReq", bus.memReq, 0);
        check("midreset terr", timeout_err, 0);
        check("midreset addrc", addr_to_caches, 0);
        #1 reset = 1'b0;

        // Both ports hold RD with immediate acks: strict alternation from cache0.
        rr_want[0] = 2'b01; rr_want[1] = 2'b10; rr_want[2] = 2'b01; rr_want[3] = 2'b10;
        set_req(RD, 16'h0A00, 16'h0, RD, 16'h0B00, 16'h0);
        bus.memAck = 1'b1;
        for (int i = 0; i < 12; i++) begin
            bus.memRdata = WW'(16'hC000 + i);
            step();
            if (i % 3 == 0) rr_seen[i / 3] = grant;
        end
        for (int i = 0; i < 4; i++) check("rr grant", rr_seen[i], rr_want[i]);
        bus.memAck = 1'b0;
        set_req(IDEL, '0, '0, IDEL, '0, '0);
        step();

        // Randomized traffic, including withdrawals during BUSY and stray acks.
        for (int n = 0; n < 3000; n++) begin
            int r0 = $urandom_range(0, 9);
            int r1 = $urandom_range(0, 9);
            rw0   = (r0 < 3) ? RD : (r0 < 6) ? WT : (r0 < 9) ? IDEL : ILL;
            rw1   = (r1 < 3) ? RD : (r1 < 6) ? WT : (r1 < 9) ? IDEL : ILL;
            addr0 = AW'($urandom);
            addr1 = AW'($urandom);
            data0 = WW'($urandom);
            data1 = WW'($urandom);
            bus.memAck   = ($urandom_range(0, 99) < 40);
            bus.memRdata = WW'($urandom);
            step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
